serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised bit-serial subtractor that computes diff = a - b - bin over WIDTH bits.
- Uses one full-subtractor cell and processes one bit per clock, LSB first.
- Successor to the single-bit half subtractor. It adds width generalisation, borrow-in, a start/ready/done handshake and signed-overflow detection.
- Sits in the combinational/arithmetic library as the area-minimal multi-bit subtract option.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous active-high reset
start  input   1      request; sampled only when ready=1
a      input   WIDTH  minuend; sampled with start
b      input   WIDTH  subtrahend; sampled with start
bin    input   1      borrow-in; sampled with start
ready  output  1      high in IDLE; block accepts start
busy   output  1      high in RUN
done   output  1      one-cycle pulse; diff/bout/ovf newly valid
diff   output  WIDTH  registered difference (a - b - bin) mod 2^WIDTH
bout   output  1      final borrow-out; 1 iff a < b + bin (unsigned)
ovf    output  1      signed overflow of two's-complement subtraction

Behaviour:
- Reset:
  - Clock and reset: single clock domain, rst synchronous active-high.
  - At a clk edge with rst=1: state=IDLE; ready=1; busy=0; done=0; diff=0; bout=0; ovf=0.
  - Internal shift registers and the counter are cleared.
  - rst has priority over start and over any in-flight operation.
  - A reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE. Outputs ready = (state==IDLE), busy = (state==RUN), done = (state==DONE).
- IDLE:
  - On an edge with start=1: load a into shift reg A, b into shift reg B, bin into borrow reg BR; cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - Bit cell: d = A[0]^B[0]^BR; br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&BR).
  - Shift d into the MSB of the result shift reg R; shift A and B right by one; BR = br_next; cnt = cnt+1.
  - Capture the MSBs of the operands at load for the ovf calculation.
  - When cnt reaches WIDTH-1 on this edge (last bit): go to DONE.
  - On that same edge, load diff = the completed R (including the last bit), bout = br_next, and ovf = (a_msb != b_msb) && (diff_msb != a_msb).
- DONE: one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - If start is sampled at edge E0, done is high in the cycle following edge E0+WIDTH.
  - Total occupancy is WIDTH+2 cycles from start to the next accepted start.
  - For WIDTH=1, done follows the edge after load.
- Result holding: diff/bout/ovf hold their values after done until the next operation's final edge or reset. They do not change during RUN.
- Handshake:
  - start while ready=0 (RUN or DONE) is ignored and not queued.
  - Operands and bin only need to be valid on the edge where start is accepted.
  - Later changes to a, b or bin do not affect the in-flight result.
- Counter: width $clog2(WIDTH+1); it must not wrap for WIDTH up to 64.
- Arithmetic:
  - Full-width modular result; bout is the unsigned borrow.
  - ovf treats a, b and diff as two's complement and does not include bin in the sign test beyond its effect on diff.

Test Plan:
- WIDTH=1, bin=0, exhaustive a,b in {00,01,10,11} → diff/bout = 0/0, 1/1, 1/0, 0/0; done exactly 1 edge after load; ready returns 1 cycle later.
- WIDTH=8: 0x05-0x03 bin=0 → diff=0x02, bout=0, ovf=0. 0x03-0x05 → diff=0xFE, bout=1, ovf=0. done exactly 8 edges after the start edge, high for one cycle.
- WIDTH=8 signed edges:
  - 0x80-0x01 → diff=0x7F, bout=0, ovf=1.
  - 0x7F-0xFF → diff=0x80, bout=1, ovf=1.
  - 0x00-0x00 bin=1 → diff=0xFF, bout=1, ovf=0.
- Handshake: assert start with 0x10-0x01, then hold start=1 with new operands 0xAA-0x55 during RUN/DONE → first result 0x0F only; second op accepted only at the first IDLE edge, then gives 0x55.
- Reset mid-operation: start 0x05-0x03, assert rst at RUN edge 3 → no done; all outputs 0 next cycle; ready=1; a new start then completes normally with the correct result.
- Randomised self-check, WIDTH=16: 500 random a, b, bin against the reference model {bout,diff} = {1'b0,a} - b - bin and the ovf formula → zero mismatches; diff stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor; the master drives
// start with its operands and the slave returns the handshake and result.
`timescale 1ns/1ps
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor cell, LSB first; done pulses WIDTH+1 cycles after start.
// start is honoured only while ready is high; requests in RUN/DONE are dropped, not queued.
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  s
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_bout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_r_next;

    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // New bit enters at the MSB so after WIDTH steps the LSB-first stream is aligned.
    assign w_r_next  = (r_r >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        s.ready      = 1'b0;
        s.busy       = 1'b0;
        s.done       = 1'b0;
        case (r_state)
            IDLE: begin
                s.ready = 1'b1;
                if (s.start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                s.busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                s.done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_diff  <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= s.a;
                r_b     <= s.b;
                r_br    <= s.bin;
                r_r     <= '0;
                r_cnt   <= '0;
                r_a_msb <= s.a[WIDTH-1];
                r_b_msb <= s.b[WIDTH-1];
            end
            if (w_step) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_br  <= w_br_next;
                r_r   <= w_r_next;
                r_cnt <= r_cnt + CW'(1);
                // Published results only change on the final bit, so they hold through RUN.
                if (w_last) begin
                    r_diff <= w_r_next;
                    r_bout <= w_br_next;
                    r_ovf  <= (r_a_msb != r_b_msb) && (w_r_next[WIDTH-1] != r_a_msb);
                end
            end
        end
    end

    assign s.diff = r_diff;
    assign s.bout = r_bout;
    assign s.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: WIDTH=1, 8 and 16 instances, directed vectors plus a random run on WIDTH=16.
`timescale 1ns/1ps
module tb_serial_subtractor;
    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b1;
    logic rst8 = 1'b1;
    logic rst16 = 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    exp_t        q[3][$];
    logic [63:0] last[3];
    logic        rstq[3];
    logic        prev_done[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            last[i]      = '0;
            rstq[i]      = 1'b1;
            prev_done[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        rstq[0] <= rst1;
        rstq[1] <= rst8;
        rstq[2] <= rst16;
    end

    serial_subtractor_if #(.WIDTH(1))  if1 ();
    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst1),  .s(if1));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .s(if8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .s(if16));

    function automatic int wid(int id);
        return (id == 0) ? 1 : ((id == 1) ? 8 : 16);
    endfunction

    task automatic chk(int id, string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut_w=%0d cyc=%0d actual=%0h required=%0h", name, wid(id), cyc, act, req);
        end
    endtask

    task automatic mon(int id, logic done, logic ready, logic busy,
                       logic [63:0] diff, logic bout, logic ovf);
        exp_t e;
        if (rstq[id]) begin
            chk(id, "reset_ready", 64'(ready), 64'd1);
            chk(id, "reset_busy",  64'(busy),  64'd0);
            chk(id, "reset_done",  64'(done),  64'd0);
            chk(id, "reset_diff",  diff,       64'd0);
            chk(id, "reset_bout",  64'(bout),  64'd0);
            chk(id, "reset_ovf",   64'(ovf),   64'd0);
            last[id]      = '0;
            prev_done[id] = 1'b0;
        end else begin
            if (prev_done[id]) chk(id, "ready_after_done", 64'(ready), 64'd1);
            if (done) begin
                if (q[id].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done dut_w=%0d cyc=%0d actual=1 required=0", wid(id), cyc);
                end else begin
                    e = q[id].pop_front();
                    chk(id, "diff",       diff,       e.diff);
                    chk(id, "bout",       64'(bout),  64'(e.bout));
                    chk(id, "ovf",        64'(ovf),   64'(e.ovf));
                    chk(id, "done_cycle", 64'(cyc),   64'(e.cyc));
                    chk(id, "done_busy",  64'(busy),  64'd0);
                    chk(id, "done_ready", 64'(ready), 64'd0);
                end
                last[id] = diff;
            end else begin
                chk(id, "diff_hold", diff, last[id]);
                if (q[id].size() != 0 && cyc > q[id][0].cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_done dut_w=%0d cyc=%0d actual=0 required=1", wid(id), cyc);
                    e = q[id].pop_front();
                end
            end
            prev_done[id] = done;
        end
    endtask

    always @(negedge clk) mon(0, if1.done,  if1.ready,  if1.busy,  64'(if1.diff),  if1.bout,  if1.ovf);
    always @(negedge clk) mon(1, if8.done,  if8.ready,  if8.busy,  64'(if8.diff),  if8.bout,  if8.ovf);
    always @(negedge clk) mon(2, if16.done, if16.ready, if16.busy, 64'(if16.diff), if16.bout, if16.ovf);

    task automatic drive(int id, logic st, logic [63:0] a, logic [63:0] b, logic bi);
        case (id)
            0: begin if1.start = st;  if1.a = a[0:0];   if1.b = b[0:0];   if1.bin = bi;  end
            1: begin if8.start = st;  if8.a = a[7:0];   if8.b = b[7:0];   if8.bin = bi;  end
            default: begin if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.bin = bi; end
        endcase
    endtask

    task automatic push(int id, logic [63:0] ed, logic eb, logic eo, int at);
        exp_t e;
        e.diff = ed;
        e.bout = eb;
        e.ovf  = eo;
        e.cyc  = at;
        q[id].push_back(e);
    endtask

    // Entered at a negedge while the DUT is idle; leaves at the first negedge it is idle again.
    task automatic op(int id, logic [63:0] a, logic [63:0] b, logic bi,
                      logic [63:0] ed, logic eb, logic eo);
        push(id, ed, eb, eo, cyc + 1 + wid(id));
        drive(id, 1'b1, a, b, bi);
        @(negedge clk);
        drive(id, 1'b0, ~a, ~b, ~bi);
        repeat (wid(id) + 1) @(negedge clk);
    endtask

    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic bi);
        exp_t        e;
        logic [64:0] f;
        logic [63:0] m;
        m      = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        f      = {1'b0, a & m} - {1'b0, b & m} - 65'(bi);
        e.diff = f[63:0] & m;
        e.bout = f[w];
        e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
        e.cyc  = 0;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rbi;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst1  = 1'b0;
        rst8  = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);

        // WIDTH=1 exhaustive
        op(0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        op(0, 64'd0, 64'd1, 1'b0, 64'd1, 1'b1, 1'b1);
        op(0, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0);
        op(0, 64'd1, 64'd1, 1'b0, 64'd0, 1'b0, 1'b0);

        // WIDTH=8 directed
        op(1, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, 1'b0);
        op(1, 64'h03, 64'h05, 1'b0, 64'hFE, 1'b1, 1'b0);
        op(1, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1);
        op(1, 64'h7F, 64'hFF, 1'b0, 64'h80, 1'b1, 1'b1);
        op(1, 64'h00, 64'h00, 1'b1, 64'hFF, 1'b1, 1'b0);

        // start held through RUN/DONE: second op lands on the first IDLE edge
        push(1, 64'h0F, 1'b0, 1'b0, cyc + 9);
        push(1, 64'h55, 1'b0, 1'b1, cyc + 19);
        drive(1, 1'b1, 64'h10, 64'h01, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, 64'hAA, 64'h55, 1'b0);
        repeat (10) @(negedge clk);
        drive(1, 1'b0, 64'h00, 64'h00, 1'b0);
        repeat (9) @(negedge clk);

        // reset on the third RUN edge aborts without a done pulse
        drive(1, 1'b1, 64'h05, 64'h03, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 64'h00, 64'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk(1, "abort_ready", 64'(if8.ready), 64'd1);
        chk(1, "abort_busy",  64'(if8.busy),  64'd0);
        op(1, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, 1'b0);

        // WIDTH=16 random against the reference model
        for (int i = 0; i < 500; i++) begin
            ra  = 64'($urandom_range(0, 65535));
            rb  = 64'($urandom_range(0, 65535));
            rbi = 1'($urandom_range(0, 1));
            e   = model(16, ra, rb, rbi);
            op(2, ra, rb, rbi, e.diff, e.bout, e.ovf);
        end

        for (int k = 0; k < 50; k++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
            @(negedge clk);
        end
        for (int id = 0; id < 3; id++) begin
            chk(id, "queue_empty", 64'(q[id].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
